// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit for the multicycle MIPS datapath.
// Operands are converted to magnitudes on acceptance, processed by an
// unsigned shift-add multiplier or restoring divider over WIDTH cycles,
// then sign-corrected and written to the HI/LO registers.
//
// Handshake: a start is accepted only on an edge where the unit is in IDLE
// and busy is low. The unit then holds busy high until the cycle after the
// one-cycle done pulse. Starts seen while busy is high are dropped, not queued.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               op_div_q, op_div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH:0]     ma_q, ma_d;
  logic [WIDTH:0]     mb_q, mb_d;
  // acc_hi: partial product high half (mult) or partial remainder (div).
  // acc_lo: multiplier shifting out (mult) or dividend/quotient (div).
  logic [WIDTH:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  // Magnitudes of the incoming operands; WIDTH+1 bits so -2^(WIDTH-1) fits.
  logic [WIDTH:0]     mag_a, mag_b;
  assign mag_a = A[WIDTH-1] ? -{1'b1, A} : {1'b0, A};
  assign mag_b = B[WIDTH-1] ? -{1'b1, B} : {1'b0, B};

  // One shift-add step: add multiplicand when the current multiplier bit is set.
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = acc_hi_q + (acc_lo_q[0] ? ma_q : '0);

  // One restoring-divide step: shift in next dividend bit and trial-subtract.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  assign div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - mb_q;
  assign div_ge    = (div_shift >= mb_q);

  // Sign-corrected results used in FINISH.
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_mag = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = sa_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

  // Next-state and datapath update for the IDLE/CALC/FINISH sequence.
  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          // Cycle carrying the done pulse: drop busy, ignore any start.
          busy_d = 1'b0;
        end else if (start_mult || start_div) begin
          op_div_d = ~start_mult;
          sa_d     = A[WIDTH-1];
          sb_d     = B[WIDTH-1];
          ma_d     = mag_a;
          mb_d     = mag_b;
          acc_hi_d = '0;
          acc_lo_d = start_mult ? mag_b[WIDTH-1:0] : mag_a[WIDTH-1:0];
          cnt_d    = '0;
          busy_d   = 1'b1;
          dz_d     = 1'b0;
          state_d  = (!start_mult && (B == '0)) ? FINISH : CALC;
        end
      end
      CALC: begin
        if (op_div_q) begin
          acc_hi_d = div_ge ? div_diff : div_shift;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (op_div_q && (mb_q == '0)) begin
          dz_d = 1'b1;
        end else if (op_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign HI        = hi_q;
  assign LO        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: reset checks, a directed vector table, busy-start
// rejection, mid-operation reset, and randomized operations against a
// plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .A          (A),
    .B          (B),
    .HI         (HI),
    .LO         (LO),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .dbg_state  (dbg_state)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: signed 64-bit arithmetic, C-style truncating division.
  task automatic model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (!is_div) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = prev_hi;
      lo = prev_lo;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  // Issue one request and check result, latency, busy and done shape.
  task automatic do_op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int elat, input string name);
    int cyc;
    int gaps;
    logic got;
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    A = a;
    B = b;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    A = $urandom;
    B = $urandom;
    cyc  = 1;
    gaps = 0;
    got  = 1'b0;
    while (cyc <= 100) begin
      if (!busy) gaps++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, got ? 64'(cyc) : 64'hFFFF_FFFF, 64'(elat));
    check({name, "_busy_gaps"}, 64'(gaps), 64'd0);
    if (got) begin
      check({name, "_hi"}, 64'(HI), 64'(ehi));
      check({name, "_lo"}, 64'(LO), 64'(elo));
      check({name, "_div_zero"}, 64'(div_zero), 64'(edz));
      @(negedge clk);
      check({name, "_done_drop"}, {62'd0, done, busy}, 64'd0);
    end
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  function automatic logic [31:0] rand_operand(input bit allow_zero);
    int pick;
    pick = $urandom_range(0, 7);
    case (pick)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 40)) - 32'd20;
      3: return allow_zero ? 32'd0 : 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    int dones;
    int done_cyc;
    logic [31:0] cap_hi, cap_lo;
    logic [31:0] ehi, elo;
    logic edz, is_div;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
    vecs[1] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[2] = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFFE, 32'd1,          32'hFFFF_FFFD, 1'b0, 34};
    vecs[3] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          32'h8000_0000, 1'b0, 34};
    vecs[4] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          32'h8000_0000, 1'b0, 34};
    vecs[5] = '{1'b0, 1'b1, 32'h451,        32'h20,        32'h11,         32'h22,         1'b0, 34};
    vecs[6] = '{1'b0, 1'b1, 32'd5,          32'd0,         32'h11,         32'h22,         1'b1, 2};
    vecs[7] = '{1'b1, 1'b0, 32'd3,          32'd4,         32'd0,          32'd12,         1'b0, 34};

    // Reset
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    A          = '0;
    B          = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].sm, vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
            vecs[i].dz, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Busy-start rejection: a div mid-operation and a mult in the done cycle
    @(negedge clk);
    start_mult = 1'b1;
    A = 32'd100;
    B = 32'hFFFF_FFFB;
    @(negedge clk);
    start_mult = 1'b0;
    A = 32'd55;
    B = 32'd66;
    dones    = 0;
    done_cyc = -1;
    cap_hi   = '0;
    cap_lo   = '0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      start_mult = 1'b0;
      start_div  = (cyc == 10);
      if (cyc == 10) begin
        A = 32'd9;
        B = 32'd2;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc   = cyc;
          cap_hi     = HI;
          cap_lo     = LO;
          start_mult = 1'b1;
        end
      end
      @(negedge clk);
    end
    start_mult = 1'b0;
    start_div  = 1'b0;
    check("busy_rej_dones", 64'(dones), 64'd1);
    check("busy_rej_latency", 64'(done_cyc), 64'd34);
    check("busy_rej_hi", 64'(cap_hi), 64'hFFFF_FFFF);
    check("busy_rej_lo", 64'(cap_lo), 64'hFFFF_FE0C);
    check("busy_rej_idle", 64'(busy), 64'd0);
    prev_hi = 32'hFFFF_FFFF;
    prev_lo = 32'hFFFF_FE0C;

    // Reset in the middle of a multiply
    @(negedge clk);
    start_mult = 1'b1;
    A = 32'd6;
    B = 32'd7;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_hi", 64'(HI), 64'd0);
    check("midrst_lo", 64'(LO), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    do_op(1'b1, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, "after_rst");

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      is_div = 1'($urandom_range(0, 1));
      ra = rand_operand(1'b0);
      rb = rand_operand(1'b1);
      model(is_div, ra, rb, ehi, elo, edz);
      do_op(~is_div, is_div, ra, rb, ehi, elo, edz,
            (is_div && rb == 32'd0) ? 2 : 34, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit for the multicycle MIPS datapath.
- Sits downstream of the control unit: the control unit pulses a start, holds its state until `done`, then selects HI/LO through the register write-back mux (mfhi/mflo).
- Operands come from the A/B datapath registers.
- Results persist in internal HI/LO registers until the next completed operation.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-low: clears all state the instant it goes low.
- start_mult  input  1  1-cycle request: signed A*B.
- start_div  input  1  1-cycle request: signed A/B.
- A  input  WIDTH  multiplicand / dividend, sampled only on the accepting edge.
- B  input  WIDTH  multiplier / divisor, sampled only on the accepting edge.
- HI  output  WIDTH  mult: upper product half; div: remainder.
- LO  output  WIDTH  mult: lower product half; div: quotient.
- busy  output  1  high from the accepting edge until `done` deasserts.
- done  output  1  registered 1-cycle pulse; HI/LO are valid in the same cycle.
- div_zero  output  1  registered; set with `done` when a divide had B==0; cleared on the next accepted start.

Behaviour:
- Reset (reset=0) forces: HI=0, LO=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- States: IDLE, CALC, FINISH.
- IDLE:
  - On an edge with start_mult or start_div high, the request is accepted.
  - start_mult has priority when both are high.
  - On acceptance: latch op, latch sign flags (A[WIDTH-1], B[WIDTH-1]), convert A and B to WIDTH+1-bit magnitudes, clear the accumulator, set counter=0, busy=1, div_zero=0, state=CALC.
  - Divide with B==0: go straight to FINISH with div_zero pending; HI/LO are left unchanged.
- CALC:
  - One iteration per cycle; exactly WIDTH iterations (counter 0..WIDTH-1).
  - Mult: unsigned shift-add on the magnitudes.
  - Div: unsigned restoring divide on the magnitudes.
  - The edge where counter==WIDTH-1 moves to FINISH.
- FINISH (one edge):
  - Apply sign correction.
  - Mult: product is negated if the sign flags differ.
  - Div: quotient is negated if the sign flags differ; remainder takes the sign of the dividend.
  - Write HI/LO, set done=1 and busy=1 for that cycle, then go to IDLE.
  - On the following edge: done=0, busy=0.
- Latency: request accepted at edge k → `done` high in the cycle after edge k+WIDTH+1, i.e. 34 cycles for WIDTH=32. Divide-by-zero: `done` high after edge k+1.
- Arithmetic: full 2*WIDTH-bit signed product; division truncates toward zero.
- Overflow divide (-2^(WIDTH-1) / -1): LO=0x80000000, HI=0, div_zero=0. No trap.
- Starts asserted while busy=1 (including the FINISH cycle) are ignored, not queued.
- A/B changing after the accepting edge has no effect on the result.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs zero; no `done` is produced.
- HI/LO hold their value between operations and across ignored starts.

Test Plan:
- Basic multiply: A=7, B=-3 (0xFFFFFFFD), start_mult 1 cycle → done exactly 34 cycles later; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for 34 cycles.
- Signed divide: A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then A=7, B=-2 → LO=0xFFFFFFFD, HI=1.
- Divide by zero: prior HI=0x11, LO=0x22; A=5, B=0, start_div → done 2 cycles after the start edge; div_zero=1; HI/LO remain 0x11/0x22. A following mult clears div_zero.
- Overflow and priority: A=0x80000000, B=0xFFFFFFFF, start_div and start_mult high together → multiply is performed: HI=0, LO=0x80000000. Repeat with start_div only → LO=0x80000000, HI=0.
- Busy-start rejection: start_mult accepted; start_div pulsed 10 cycles later with different A/B → single done at cycle 34 holding the original mult result; no second done.
- Reset mid-op: pull reset low for 1 cycle at iteration 15 → HI=LO=0, busy=0, done never pulses. A new start afterwards completes normally in 34 cycles.
